// File: rtl/lcd_hd44780_driver.sv
// HD44780 character-LCD timing engine: runs the power-up init sequence, then sends
// byte requests taken over valid/ready with setup / EN / hold / execution timing.
module lcd_hd44780_driver #(
  parameter int unsigned POWERUP_CYC = 375000,
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned EN_CYC      = 12,
  parameter int unsigned HOLD_CYC    = 2,
  parameter int unsigned EXEC_CYC    = 1000,
  parameter int unsigned CLEAR_CYC   = 41000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_vld,
  input  logic        i_req_rs,
  input  logic [7:0]  i_req_data,
  output logic        o_req_rdy,
  output logic        o_init_done,
  output logic [31:0] o_io_lcd
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned MAX_CYC = max2(max2(max2(POWERUP_CYC, SETUP_CYC), max2(EN_CYC, HOLD_CYC)),
                                         max2(EXEC_CYC, CLEAR_CYC));
  localparam int CW = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    S_PWRUP,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_EXEC,
    S_IDLE
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_limit;
  logic            w_cnt_last;
  logic            w_long_wait;
  logic            w_accept;
  logic            w_load_init;
  logic [7:0]      w_init_byte;

  logic            r_on;
  logic            r_en;
  logic            r_rs;
  logic [7:0]      r_data;
  logic [2:0]      r_init_idx;
  logic            r_init_busy;
  logic            r_init_done;

  // Clear/home (0x01..0x03) need the long execution wait; data writes never do.
  assign w_long_wait = ~r_rs && (r_data[7:2] == 6'd0) && (r_data != 8'd0);

  always_comb begin
    w_init_byte = 8'h06;
    case (r_init_idx)
      3'd0:    w_init_byte = 8'h38;
      3'd1:    w_init_byte = 8'h0C;
      3'd2:    w_init_byte = 8'h01;
      default: w_init_byte = 8'h06;
    endcase
  end

  always_comb begin
    w_limit = CW'(1);
    case (r_state)
      S_PWRUP: w_limit = CW'(POWERUP_CYC);
      S_SETUP: w_limit = CW'(SETUP_CYC);
      S_PULSE: w_limit = CW'(EN_CYC);
      S_HOLD:  w_limit = CW'(HOLD_CYC);
      S_EXEC:  w_limit = w_long_wait ? CW'(CLEAR_CYC) : CW'(EXEC_CYC);
      default: w_limit = CW'(1);
    endcase
  end

  assign w_cnt_last = (r_cnt == (w_limit - CW'(1)));

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_load_init  = 1'b0;
    case (r_state)
      S_PWRUP: begin
        if (w_cnt_last) begin
          w_state_next = S_SETUP;
          w_load_init  = 1'b1;
        end
      end
      S_SETUP: if (w_cnt_last) w_state_next = S_PULSE;
      S_PULSE: if (w_cnt_last) w_state_next = S_HOLD;
      S_HOLD:  if (w_cnt_last) w_state_next = S_EXEC;
      S_EXEC: begin
        if (w_cnt_last) begin
          if (r_init_busy && (r_init_idx != 3'd4)) begin
            w_state_next = S_SETUP;
            w_load_init  = 1'b1;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      S_IDLE: begin
        if (i_req_vld) begin
          w_state_next = S_SETUP;
          w_accept     = 1'b1;
        end
      end
      default: w_state_next = S_PWRUP;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= S_PWRUP;
    else          r_state <= w_state_next;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_on        <= 1'b0;
      r_en        <= 1'b0;
      r_rs        <= 1'b0;
      r_data      <= 8'd0;
      r_cnt       <= '0;
      r_init_idx  <= 3'd0;
      r_init_busy <= 1'b1;
      r_init_done <= 1'b0;
    end else begin
      r_on <= 1'b1;
      // EN registered from the next state so the pin is a clean flop output.
      r_en <= (w_state_next == S_PULSE);
      if ((w_state_next != r_state) || (r_state == S_IDLE)) r_cnt <= '0;
      else                                                  r_cnt <= r_cnt + CW'(1);
      if (w_load_init) begin
        r_rs       <= 1'b0;
        r_data     <= w_init_byte;
        r_init_idx <= r_init_idx + 3'd1;
      end else if (w_accept) begin
        r_rs   <= i_req_rs;
        r_data <= i_req_data;
      end
      if ((r_state == S_EXEC) && (w_state_next == S_IDLE)) begin
        r_init_busy <= 1'b0;
        r_init_done <= 1'b1;
      end
    end
  end

  assign o_req_rdy   = (r_state == S_IDLE);
  assign o_init_done = r_init_done;
  assign o_io_lcd    = {r_on, 20'd0, r_en, r_rs, 1'b0, r_data};

endmodule
